// File: rtl/core_pipe_exec_mdu_seq_if.sv
// Bundle of the issue, MDU and writeback signals around the MDU sequencer.
//   slave  : sequencer view (accepts issue requests, drives the MDU, returns results)
//   master : surrounding pipeline + MDU view
// Parameter XLEN sets the operand/result width.
interface core_pipe_exec_mdu_seq_if #(
  parameter int unsigned XLEN = 64
);
  // issue side
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_op;
  logic            in_op_word;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [4:0]      in_rd_addr;
  // MDU side
  logic            mdu_valid;
  logic [7:0]      mdu_op;
  logic            mdu_op_word;
  logic [XLEN-1:0] mdu_rs1;
  logic [XLEN-1:0] mdu_rs2;
  logic            mdu_flush;
  logic            mdu_ready;
  logic [XLEN-1:0] mdu_rd;
  // writeback side
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd_addr;
  logic [XLEN-1:0] out_rd;

  modport slave (
    input  in_valid, in_op, in_op_word, in_rs1, in_rs2, in_rd_addr,
    output in_ready,
    output mdu_valid, mdu_op, mdu_op_word, mdu_rs1, mdu_rs2, mdu_flush,
    input  mdu_ready, mdu_rd,
    output out_valid, out_rd_addr, out_rd,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_op_word, in_rs1, in_rs2, in_rd_addr,
    input  in_ready,
    input  mdu_valid, mdu_op, mdu_op_word, mdu_rs1, mdu_rs2, mdu_flush,
    output mdu_ready, mdu_rd,
    input  out_valid, out_rd_addr, out_rd,
    output out_ready
  );
endinterface

// File: rtl/core_pipe_exec_mdu_seq.sv
// Execute-stage sequencer for a multi-cycle multiply/divide unit.
// Accepts one request at a time, holds it on the MDU port until the MDU
// completes, then spends one CLR cycle pulsing mdu_flush to re-arm the MDU's
// sticky done flag. Results are held for writeback until out_ready.
// Ports:
//   g_clk    : clock (rising edge)
//   g_reset  : synchronous active-high reset
//   flush    : pipeline flush, kills in-flight or held work
//   bus      : core_pipe_exec_mdu_seq_if.slave (issue / MDU / writeback)
// Optional feature: define CORE_MDU_RESULT_CACHE_EN to keep the operands and
// result of the last completed MDU operation and answer exact repeats in one
// cycle without touching the MDU.
module core_pipe_exec_mdu_seq #(
  parameter int unsigned XLEN = 64
) (
  input  logic                     g_clk,
  input  logic                     g_reset,
  input  logic                     flush,
  core_pipe_exec_mdu_seq_if.slave  bus
);

  localparam int unsigned OP_W = 8;
  localparam int unsigned RA_W = 5;

  typedef enum logic [1:0] {IDLE, BUSY, CLR} state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [RA_W-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic              out_valid_q, out_valid_d;

  logic              accept_c;
  logic              cache_hit_c;
  logic [XLEN-1:0]   cache_rd_c;

  assign bus.in_ready = (state_q == IDLE) && !out_valid_q && !flush;
  assign accept_c     = bus.in_valid && bus.in_ready;

`ifdef CORE_MDU_RESULT_CACHE_EN
  // Last-result cache; only a completed, non-flushed MDU operation loads it.
  logic              cache_vld_q, cache_vld_d;
  logic [OP_W-1:0]   cache_op_q, cache_op_d;
  logic              cache_word_q, cache_word_d;
  logic [XLEN-1:0]   cache_rs1_q, cache_rs1_d;
  logic [XLEN-1:0]   cache_rs2_q, cache_rs2_d;
  logic [XLEN-1:0]   cache_rd_q, cache_rd_d;

  assign cache_hit_c = cache_vld_q && (bus.in_op == cache_op_q) &&
                       (bus.in_op_word == cache_word_q) &&
                       (bus.in_rs1 == cache_rs1_q) && (bus.in_rs2 == cache_rs2_q);
  assign cache_rd_c  = cache_rd_q;

  always_comb begin
    cache_vld_d  = cache_vld_q;
    cache_op_d   = cache_op_q;
    cache_word_d = cache_word_q;
    cache_rs1_d  = cache_rs1_q;
    cache_rs2_d  = cache_rs2_q;
    cache_rd_d   = cache_rd_q;
    if ((state_q == BUSY) && bus.mdu_ready && !flush) begin
      cache_vld_d  = 1'b1;
      cache_op_d   = op_q;
      cache_word_d = word_q;
      cache_rs1_d  = rs1_q;
      cache_rs2_d  = rs2_q;
      cache_rd_d   = bus.mdu_rd;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      cache_vld_q  <= 1'b0;
      cache_op_q   <= '0;
      cache_word_q <= 1'b0;
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_rd_q   <= '0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_op_q   <= cache_op_d;
      cache_word_q <= cache_word_d;
      cache_rs1_q  <= cache_rs1_d;
      cache_rs2_q  <= cache_rs2_d;
      cache_rd_q   <= cache_rd_d;
    end
  end
`else
  assign cache_hit_c = 1'b0;
  assign cache_rd_c  = '0;
`endif

  // Next-state / capture logic; flush overrides every other transition.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    word_d      = word_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_addr_d   = rd_addr_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            op_d      = bus.in_op;
            word_d    = bus.in_op_word;
            rs1_d     = bus.in_rs1;
            rs2_d     = bus.in_rs2;
            rd_addr_d = bus.in_rd_addr;
            if (bus.in_op == '0) begin
              // No operation selected: complete immediately with zero.
              rd_d        = '0;
              out_valid_d = 1'b1;
            end else if (cache_hit_c) begin
              rd_d        = cache_rd_c;
              out_valid_d = 1'b1;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.mdu_ready) begin
            rd_d        = bus.mdu_rd;
            out_valid_d = 1'b1;
            state_d     = CLR;
          end
        end
        CLR:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      word_q      <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_addr_q   <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      word_q      <= word_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_addr_q   <= rd_addr_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.mdu_valid   = (state_q == BUSY);
  assign bus.mdu_op      = op_q;
  assign bus.mdu_op_word = word_q;
  assign bus.mdu_rs1     = rs1_q;
  assign bus.mdu_rs2     = rs2_q;
  // MDU is cleared by the CLR cycle, by a pipeline flush and during reset.
  assign bus.mdu_flush   = (state_q == CLR) || flush || g_reset;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_rd_addr = rd_addr_q;
  assign bus.out_rd      = rd_q;

endmodule

// File: tb/tb_core_pipe_exec_mdu_seq.sv
// Directed self-checking bench for core_pipe_exec_mdu_seq with a behavioural
// MDU that raises a sticky done three cycles after mdu_valid and clears it on
// mdu_flush.
module tb_core_pipe_exec_mdu_seq;
  localparam int unsigned XLEN = 64;

  logic clk = 1'b0;
  logic g_reset;
  logic flush;

  core_pipe_exec_mdu_seq_if #(.XLEN(XLEN)) bus ();

  core_pipe_exec_mdu_seq #(.XLEN(XLEN)) dut (
    .g_clk   (clk),
    .g_reset (g_reset),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural MDU
  logic [1:0]      md_cnt;
  logic            md_done;
  logic [XLEN-1:0] md_res;

  function automatic logic [XLEN-1:0] md_calc(input logic [7:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (op)
      8'h01:   md_calc = a * b;
      8'h04:   md_calc = a / b;
      8'h20:   md_calc = a % b;
      8'h80:   md_calc = a % b;
      default: md_calc = '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mdu_flush) begin
      md_cnt  <= 2'd0;
      md_done <= 1'b0;
    end else if (bus.mdu_valid && !md_done) begin
      md_cnt <= md_cnt + 2'd1;
      if (md_cnt == 2'd2) begin
        md_done <= 1'b1;
        md_res  <= md_calc(bus.mdu_op, bus.mdu_rs1, bus.mdu_rs2);
      end
    end
  end

  assign bus.mdu_ready = md_done;
  assign bus.mdu_rd    = md_res;

  // Activity monitors
  int mv_cnt;
  int mf_cnt;
  always @(posedge clk) begin
    if (bus.mdu_valid) mv_cnt++;
    if (bus.mdu_flush) mf_cnt++;
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [7:0] op,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [4:0] rd);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_op_word = 1'b0;
    bus.in_rs1     = a;
    bus.in_rs2     = b;
    bus.in_rd_addr = rd;
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.mdu_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_mdu_ready_timeout"}, 64'(bus.mdu_ready), 64'd1);
  endtask

  // Full MDU round trip with out_ready held high.
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [4:0] rd, input logic [XLEN-1:0] exp);
    issue(tag, op, a, b, rd);
    chk({tag, "_mdu_valid"}, 64'(bus.mdu_valid), 64'd1);
    wait_ready(tag);
    tick();
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_out_rd"}, 64'(bus.out_rd), 64'(exp));
    chk({tag, "_out_rd_addr"}, 64'(bus.out_rd_addr), 64'(rd));
    tick();
    chk({tag, "_out_valid_clr"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    g_reset        = 1'b1;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_op      = 8'h00;
    bus.in_op_word = 1'b0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_rd_addr = 5'd0;
    bus.out_ready  = 1'b1;
    md_cnt         = 2'd0;
    md_done        = 1'b0;
    md_res         = '0;
    mv_cnt         = 0;
    mf_cnt         = 0;

    // Reset
    tick();
    chk("rst_mdu_flush", 64'(bus.mdu_flush), 64'd1);
    tick();
    g_reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mdu_valid", 64'(bus.mdu_valid), 64'd0);
    chk("rst_mdu_flush_off", 64'(bus.mdu_flush), 64'd0);
    chk("rst_mdu_op", 64'(bus.mdu_op), 64'd0);
    chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
    chk("rst_out_rd_addr", 64'(bus.out_rd_addr), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // MUL 7*6 = 42, single mdu_flush pulse
    tick();
    mf_cnt = 0;
    issue("mul", 8'h01, 64'd7, 64'd6, 5'd4);
    chk("mul_mdu_valid", 64'(bus.mdu_valid), 64'd1);
    chk("mul_mdu_op", 64'(bus.mdu_op), 64'h01);
    chk("mul_mdu_rs1", 64'(bus.mdu_rs1), 64'd7);
    chk("mul_mdu_rs2", 64'(bus.mdu_rs2), 64'd6);
    wait_ready("mul");
    chk("mul_mdu_op_stable", 64'(bus.mdu_op), 64'h01);
    tick();
    chk("mul_out_valid", 64'(bus.out_valid), 64'd1);
    chk("mul_out_rd", 64'(bus.out_rd), 64'd42);
    chk("mul_out_rd_addr", 64'(bus.out_rd_addr), 64'd4);
    chk("mul_clr_flush", 64'(bus.mdu_flush), 64'd1);
    chk("mul_clr_valid", 64'(bus.mdu_valid), 64'd0);
    tick();
    chk("mul_out_valid_clr", 64'(bus.out_valid), 64'd0);
    chk("mul_flush_off", 64'(bus.mdu_flush), 64'd0);
    chk("mul_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("mul_flush_pulses", 64'(mf_cnt), 64'd1);

    // DIVU 100/7 = 14 with writeback stalled for 5 cycles
    bus.out_ready = 1'b0;
    issue("divu", 8'h04, 64'd100, 64'd7, 5'd7);
    wait_ready("divu");
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("divu_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("divu_hold_rd", 64'(bus.out_rd), 64'd14);
      chk("divu_hold_rd_addr", 64'(bus.out_rd_addr), 64'd7);
      chk("divu_hold_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("divu_out_valid_clr", 64'(bus.out_valid), 64'd0);
    chk("divu_in_ready", 64'(bus.in_ready), 64'd1);

    // Flush coinciding with mdu_ready discards the result
    issue("flsh", 8'h01, 64'd2, 64'd2, 5'd1);
    wait_ready("flsh");
    flush = 1'b1;
    #1;
    chk("flsh_mdu_flush", 64'(bus.mdu_flush), 64'd1);
    chk("flsh_in_ready_low", 64'(bus.in_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flsh_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flsh_mdu_valid", 64'(bus.mdu_valid), 64'd0);
    chk("flsh_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flsh_out_rd_kept", 64'(bus.out_rd), 64'd14);
    tick();
    chk("flsh_no_late_valid", 64'(bus.out_valid), 64'd0);

    // op == 0: immediate zero result, MDU untouched
    mv_cnt = 0;
    issue("nop", 8'h00, 64'd5, 64'd0, 5'd3);
    chk("nop_out_valid", 64'(bus.out_valid), 64'd1);
    chk("nop_out_rd", 64'(bus.out_rd), 64'd0);
    chk("nop_out_rd_addr", 64'(bus.out_rd_addr), 64'd3);
    chk("nop_mdu_valid", 64'(bus.mdu_valid), 64'd0);
    tick();
    chk("nop_out_valid_clr", 64'(bus.out_valid), 64'd0);
    chk("nop_mv_cnt", 64'(mv_cnt), 64'd0);

    // REM 17%5 = 2, then repeat (cache hit when enabled), then REMU
    run_op("rem1", 8'h20, 64'd17, 64'd5, 5'd10, 64'd2);
    issue("zero", 8'h00, 64'd1, 64'd1, 5'd2);
    tick();
    chk("zero_out_rd", 64'(bus.out_rd), 64'd0);
`ifdef CORE_MDU_RESULT_CACHE_EN
    mv_cnt = 0;
    issue("rem2", 8'h20, 64'd17, 64'd5, 5'd11);
    chk("rem2_out_valid", 64'(bus.out_valid), 64'd1);
    chk("rem2_out_rd", 64'(bus.out_rd), 64'd2);
    chk("rem2_out_rd_addr", 64'(bus.out_rd_addr), 64'd11);
    chk("rem2_mdu_valid", 64'(bus.mdu_valid), 64'd0);
    tick();
    chk("rem2_out_valid_clr", 64'(bus.out_valid), 64'd0);
    chk("rem2_mv_cnt", 64'(mv_cnt), 64'd0);
`else
    run_op("rem2", 8'h20, 64'd17, 64'd5, 5'd11, 64'd2);
`endif
    issue("zero2", 8'h00, 64'd1, 64'd1, 5'd2);
    tick();
    run_op("remu", 8'h80, 64'd17, 64'd5, 5'd12, 64'd2);

    // Reset while BUSY abandons the operation
    issue("rbsy", 8'h01, 64'd5, 64'd5, 5'd9);
    chk("rbsy_mdu_valid", 64'(bus.mdu_valid), 64'd1);
    g_reset = 1'b1;
    tick();
    chk("rbsy_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rbsy_mdu_valid_off", 64'(bus.mdu_valid), 64'd0);
    chk("rbsy_mdu_op", 64'(bus.mdu_op), 64'd0);
    chk("rbsy_out_rd", 64'(bus.out_rd), 64'd0);
    chk("rbsy_out_rd_addr", 64'(bus.out_rd_addr), 64'd0);
    chk("rbsy_mdu_flush", 64'(bus.mdu_flush), 64'd1);
    g_reset = 1'b0;
    tick();
    chk("rbsy_flush_off", 64'(bus.mdu_flush), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rbsy_no_output", 64'(bus.out_valid), 64'd0);
      tick();
    end
    run_op("mul9", 8'h01, 64'd3, 64'd3, 5'd5, 64'd9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
